// File: rtl/exc_ctrl.sv
// Exception/ERET controller: arbitrates memory-stage exceptions and interrupts,
// pulses the CP0 exception-write port, flushes the pipeline and redirects fetch.
module exc_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m_valid,
  input  logic        stall,
  input  logic [31:0] m_pc,
  input  logic        m_bd,
  input  logic [31:0] m_badaddr,
  input  logic        m_exc_if_adel,
  input  logic        m_exc_ri,
  input  logic        m_exc_ov,
  input  logic        m_exc_sys,
  input  logic        m_exc_bp,
  input  logic        m_exc_adel,
  input  logic        m_exc_ades,
  input  logic        m_eret,
  input  logic [7:0]  intr_vect,
  input  logic [31:0] er_epc,
  output logic        cp0w_we,
  output logic        cp0w_bd,
  output logic        cp0w_exl,
  output logic [4:0]  cp0w_exc,
  output logic [31:0] cp0w_epc,
  output logic [31:0] cp0w_bva,
  output logic        exl_clr,
  output logic        flush,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned EXC_W = 5;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               we_d, bd_d, exl_d, exl_clr_d, flush_d, redirect_d, busy_d;
  logic [EXC_W-1:0]   exc_d;
  logic [31:0]        epc_d, bva_d, rpc_d;

  logic               intr_pend, ev_exc, ev_eret, accept;
  logic [EXC_W-1:0]   exc_code;
  logic [31:0]        bva_sel;

  assign intr_pend = |intr_vect;
  assign ev_exc    = intr_pend | m_exc_if_adel | m_exc_ri | m_exc_ov | m_exc_sys |
                     m_exc_bp | m_exc_adel | m_exc_ades;
  assign ev_eret   = m_eret & ~ev_exc;
  assign accept    = m_valid & ~stall & (state == IDLE);

  // Highest-priority cause; BadVAddr only changes for address-error causes
  always_comb begin
    exc_code = EXC_W'(0);
    bva_sel  = cp0w_bva;
    if (intr_pend) begin
      exc_code = EXC_W'(8'h00);
    end else if (m_exc_if_adel) begin
      exc_code = EXC_W'(8'h04);
      bva_sel  = m_pc;
    end else if (m_exc_ri) begin
      exc_code = EXC_W'(8'h0A);
    end else if (m_exc_ov) begin
      exc_code = EXC_W'(8'h0C);
    end else if (m_exc_sys) begin
      exc_code = EXC_W'(8'h08);
    end else if (m_exc_bp) begin
      exc_code = EXC_W'(8'h09);
    end else if (m_exc_adel) begin
      exc_code = EXC_W'(8'h04);
      bva_sel  = m_badaddr;
    end else if (m_exc_ades) begin
      exc_code = EXC_W'(8'h05);
      bva_sel  = m_badaddr;
    end
  end

  // Next state and next registered outputs; write fields hold between events
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    we_d       = 1'b0;
    exl_clr_d  = 1'b0;
    redirect_d = 1'b0;
    flush_d    = 1'b0;
    busy_d     = 1'b0;
    bd_d       = cp0w_bd;
    exl_d      = cp0w_exl;
    exc_d      = cp0w_exc;
    epc_d      = cp0w_epc;
    bva_d      = cp0w_bva;
    rpc_d      = redirect_pc;
    case (state)
      IDLE: begin
        if (accept && (ev_exc || ev_eret)) begin
          state_d    = FLUSH;
          cnt_d      = CNT_W'(FLUSH_CYCLES - 1);
          flush_d    = 1'b1;
          busy_d     = 1'b1;
          redirect_d = 1'b1;
          if (ev_exc) begin
            we_d  = 1'b1;
            bd_d  = m_bd;
            exl_d = 1'b1;
            exc_d = exc_code;
            epc_d = m_bd ? (m_pc - 32'd4) : m_pc;
            bva_d = bva_sel;
            rpc_d = EXC_VECTOR;
          end else begin
            exl_clr_d = 1'b1;
            rpc_d     = er_epc;
          end
        end
      end
      FLUSH: begin
        if (cnt == CNT_W'(0)) begin
          state_d = IDLE;
        end else begin
          cnt_d   = cnt - CNT_W'(1);
          flush_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= CNT_W'(0);
      cp0w_we     <= 1'b0;
      cp0w_bd     <= 1'b0;
      cp0w_exl    <= 1'b0;
      cp0w_exc    <= EXC_W'(0);
      cp0w_epc    <= 32'd0;
      cp0w_bva    <= 32'd0;
      exl_clr     <= 1'b0;
      flush       <= 1'b0;
      redirect    <= 1'b0;
      redirect_pc <= 32'd0;
      busy        <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      cp0w_we     <= we_d;
      cp0w_bd     <= bd_d;
      cp0w_exl    <= exl_d;
      cp0w_exc    <= exc_d;
      cp0w_epc    <= epc_d;
      cp0w_bva    <= bva_d;
      exl_clr     <= exl_clr_d;
      flush       <= flush_d;
      redirect    <= redirect_d;
      redirect_pc <= rpc_d;
      busy        <= busy_d;
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Bench for exc_ctrl: directed scenarios plus randomized traffic against a
// transaction-level model of cause priority and flush timing.
module tb_exc_ctrl;

  localparam int unsigned FC = 2;
  localparam logic [31:0] VEC = 32'hBFC00380;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m_valid, stall, m_bd, m_eret;
  logic [31:0] m_pc, m_badaddr, er_epc;
  logic        m_exc_if_adel, m_exc_ri, m_exc_ov, m_exc_sys, m_exc_bp, m_exc_adel, m_exc_ades;
  logic [7:0]  intr_vect;
  logic        cp0w_we, cp0w_bd, cp0w_exl, exl_clr, flush, redirect, busy;
  logic [4:0]  cp0w_exc;
  logic [31:0] cp0w_epc, cp0w_bva, redirect_pc;

  int passed = 0;
  int total  = 0;

  exc_ctrl #(.FLUSH_CYCLES(FC), .EXC_VECTOR(VEC)) dut (
    .clk(clk), .rst(rst), .m_valid(m_valid), .stall(stall), .m_pc(m_pc), .m_bd(m_bd),
    .m_badaddr(m_badaddr), .m_exc_if_adel(m_exc_if_adel), .m_exc_ri(m_exc_ri),
    .m_exc_ov(m_exc_ov), .m_exc_sys(m_exc_sys), .m_exc_bp(m_exc_bp),
    .m_exc_adel(m_exc_adel), .m_exc_ades(m_exc_ades), .m_eret(m_eret),
    .intr_vect(intr_vect), .er_epc(er_epc), .cp0w_we(cp0w_we), .cp0w_bd(cp0w_bd),
    .cp0w_exl(cp0w_exl), .cp0w_exc(cp0w_exc), .cp0w_epc(cp0w_epc), .cp0w_bva(cp0w_bva),
    .exl_clr(exl_clr), .flush(flush), .redirect(redirect), .redirect_pc(redirect_pc),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    m_valid = 0; stall = 0; m_bd = 0; m_eret = 0; m_pc = 0; m_badaddr = 0; er_epc = 0;
    m_exc_if_adel = 0; m_exc_ri = 0; m_exc_ov = 0; m_exc_sys = 0; m_exc_bp = 0;
    m_exc_adel = 0; m_exc_ades = 0; intr_vect = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    step(); step();
    total++;
    if ({cp0w_we, cp0w_bd, cp0w_exl, cp0w_exc, cp0w_epc, cp0w_bva, exl_clr, flush, redirect,
         redirect_pc, busy} !== '0)
      $display("FAIL reset_outputs got we=%0b flush=%0b busy=%0b epc=%h rpc=%h exp all 0",
               cp0w_we, flush, busy, cp0w_epc, redirect_pc);
    else passed++;
    rst = 0;
    step();
  endtask

  task automatic test_ov();
    m_valid = 1; m_exc_ov = 1; m_pc = 32'h80001000;
    step();
    clear_inputs();
    total++; if (cp0w_we !== 1'b1) $display("FAIL ov_we got %0b exp 1", cp0w_we); else passed++;
    total++; if (cp0w_exc !== 5'h0C) $display("FAIL ov_exc got %h exp 0c", cp0w_exc); else passed++;
    total++; if (cp0w_epc !== 32'h80001000) $display("FAIL ov_epc got %h exp 80001000", cp0w_epc); else passed++;
    total++; if (cp0w_exl !== 1'b1) $display("FAIL ov_exl got %0b exp 1", cp0w_exl); else passed++;
    total++; if (redirect_pc !== VEC || redirect !== 1'b1)
      $display("FAIL ov_redirect got %0b/%h exp 1/%h", redirect, redirect_pc, VEC); else passed++;
    total++; if (flush !== 1'b1) $display("FAIL ov_flush_t1 got %0b exp 1", flush); else passed++;
    step();
    total++; if ({flush, cp0w_we, redirect} !== 3'b100)
      $display("FAIL ov_t2 got flush/we/redir=%b exp 100", {flush, cp0w_we, redirect}); else passed++;
    step();
    total++; if ({busy, flush} !== 2'b00)
      $display("FAIL ov_t3_idle got busy/flush=%b exp 00", {busy, flush}); else passed++;
  endtask

  task automatic test_ades_bd();
    m_valid = 1; m_exc_ades = 1; m_bd = 1; m_pc = 32'h80000104; m_badaddr = 32'h3;
    step();
    clear_inputs();
    total++; if ({cp0w_we, cp0w_exc, cp0w_bd} !== {1'b1, 5'h05, 1'b1})
      $display("FAIL ades_we_exc_bd got %0b/%h/%0b exp 1/05/1", cp0w_we, cp0w_exc, cp0w_bd); else passed++;
    total++; if (cp0w_epc !== 32'h80000100) $display("FAIL ades_epc got %h exp 80000100", cp0w_epc); else passed++;
    total++; if (cp0w_bva !== 32'h3) $display("FAIL ades_bva got %h exp 00000003", cp0w_bva); else passed++;
    step(); step();
    // branch-delay EPC wraps below zero
    m_valid = 1; m_exc_if_adel = 1; m_bd = 1; m_pc = 32'h0;
    step();
    clear_inputs();
    total++; if ({cp0w_exc, cp0w_epc, cp0w_bva} !== {5'h04, 32'hFFFFFFFC, 32'h0})
      $display("FAIL ifadel_wrap got exc=%h epc=%h bva=%h exp 04/fffffffc/0", cp0w_exc, cp0w_epc, cp0w_bva);
    else passed++;
    step(); step();
  endtask

  task automatic test_int();
    m_valid = 1; m_exc_ri = 1; intr_vect = 8'h04; m_pc = 32'h80000200;
    step();
    clear_inputs();
    total++; if ({cp0w_we, cp0w_exc} !== {1'b1, 5'h00})
      $display("FAIL int_prio got we=%0b exc=%h exp 1/00", cp0w_we, cp0w_exc); else passed++;
    step(); step();
    intr_vect = 8'h04;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if ({cp0w_we, redirect, flush} !== 3'b000)
        $display("FAIL int_novalid got we/redir/flush=%b exp 000", {cp0w_we, redirect, flush}); else passed++;
    end
    clear_inputs();
  endtask

  task automatic test_eret_busy();
    m_valid = 1; m_eret = 1; er_epc = 32'h80002000;
    step();
    clear_inputs();
    total++; if ({exl_clr, cp0w_we, flush} !== 3'b101)
      $display("FAIL eret_pulse got exl_clr/we/flush=%b exp 101", {exl_clr, cp0w_we, flush}); else passed++;
    total++; if (redirect_pc !== 32'h80002000 || redirect !== 1'b1)
      $display("FAIL eret_rpc got %0b/%h exp 1/80002000", redirect, redirect_pc); else passed++;
    m_valid = 1; m_exc_sys = 1;
    step();
    total++; if ({exl_clr, cp0w_we, redirect} !== 3'b000)
      $display("FAIL busy_ignore got exl_clr/we/redir=%b exp 000", {exl_clr, cp0w_we, redirect}); else passed++;
    clear_inputs();
    step();
    total++; if ({busy, cp0w_we} !== 2'b00)
      $display("FAIL eret_done got busy/we=%b exp 00", {busy, cp0w_we}); else passed++;
    // exception alongside ERET: exception wins
    m_valid = 1; m_eret = 1; m_exc_bp = 1; m_pc = 32'h80000300;
    step();
    clear_inputs();
    total++; if ({cp0w_we, exl_clr, cp0w_exc} !== {1'b1, 1'b0, 5'h09})
      $display("FAIL eret_vs_bp got we=%0b exl_clr=%0b exc=%h exp 1/0/09", cp0w_we, exl_clr, cp0w_exc);
    else passed++;
    step(); step();
  endtask

  task automatic test_stall_reset();
    int pulses = 0;
    m_valid = 1; m_exc_sys = 1; stall = 1; m_pc = 32'h80000400;
    for (int i = 0; i < 3; i++) begin
      step();
      pulses += int'(cp0w_we);
    end
    stall = 0;
    step();
    clear_inputs();
    total++; if (cp0w_we !== 1'b1 || pulses != 0 || cp0w_exc !== 5'h08)
      $display("FAIL stall_release got we=%0b early=%0d exc=%h exp 1/0/08", cp0w_we, pulses, cp0w_exc);
    else passed++;
    rst = 1;
    step();
    rst = 0;
    total++; if ({cp0w_we, cp0w_bd, cp0w_exl, cp0w_exc, cp0w_epc, cp0w_bva, exl_clr, flush, redirect,
                  redirect_pc, busy} !== '0)
      $display("FAIL mid_flush_reset got we=%0b flush=%0b busy=%0b epc=%h exp all 0",
               cp0w_we, flush, busy, cp0w_epc);
    else passed++;
    step();
    total++; if ({cp0w_we, flush, busy, redirect} !== 4'b0000)
      $display("FAIL after_reset got we/flush/busy/redir=%b exp 0000", {cp0w_we, flush, busy, redirect});
    else passed++;
  endtask

  task automatic test_random();
    int          rem;
    logic        e_we, e_bd, e_exl, e_clr, e_redir;
    logic [4:0]  e_exc;
    logic [31:0] e_epc, e_bva, e_rpc;
    logic [7:0]  f;
    int          codes [8] = '{0, 4, 10, 12, 8, 9, 4, 5};
    int          first;
    logic [106:0] got, exp;
    rst = 1; clear_inputs(); step(); rst = 0;
    rem = 0; e_bd = 0; e_exl = 0; e_exc = 0; e_epc = 0; e_bva = 0; e_rpc = 0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      m_valid = ($urandom_range(0, 3) != 0);
      stall   = ($urandom_range(0, 3) == 0);
      m_pc    = ($urandom_range(0, 15) == 0) ? 32'h0 : $urandom;
      m_bd    = $urandom_range(0, 1) == 1;
      m_badaddr = $urandom; er_epc = $urandom;
      m_exc_if_adel = ($urandom_range(0, 15) == 0); m_exc_ri   = ($urandom_range(0, 15) == 0);
      m_exc_ov      = ($urandom_range(0, 15) == 0); m_exc_sys  = ($urandom_range(0, 15) == 0);
      m_exc_bp      = ($urandom_range(0, 15) == 0); m_exc_adel = ($urandom_range(0, 15) == 0);
      m_exc_ades    = ($urandom_range(0, 15) == 0); m_eret     = ($urandom_range(0, 4) == 0);
      intr_vect     = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      rst = ($urandom_range(0, 59) == 0);
      f = {m_exc_ades, m_exc_adel, m_exc_bp, m_exc_sys, m_exc_ov, m_exc_ri, m_exc_if_adel,
           intr_vect != 8'h00};
      first = -1;
      for (int k = 7; k >= 0; k--) if (f[k]) first = k;
      e_we = 0; e_clr = 0; e_redir = 0;
      if (rst) begin
        rem = 0; e_bd = 0; e_exl = 0; e_exc = 0; e_epc = 0; e_bva = 0; e_rpc = 0;
      end else if (m_valid && !stall && rem == 0 && (first >= 0 || m_eret)) begin
        rem = FC; e_redir = 1;
        if (first >= 0) begin
          e_we = 1; e_bd = m_bd; e_exl = 1; e_exc = 5'(codes[first]);
          e_epc = m_bd ? m_pc - 32'd4 : m_pc;
          if (first == 1) e_bva = m_pc;
          else if (first >= 6) e_bva = m_badaddr;
          e_rpc = VEC;
        end else begin
          e_clr = 1; e_rpc = er_epc;
        end
      end else if (rem > 0) begin
        rem--;
      end
      exp = {e_we, e_bd, e_exl, e_exc, e_epc, e_bva, e_clr, rem > 0, e_redir, e_rpc, rem > 0};
      step();
      got = {cp0w_we, cp0w_bd, cp0w_exl, cp0w_exc, cp0w_epc, cp0w_bva, exl_clr, flush, redirect,
             redirect_pc, busy};
      total++;
      if (got !== exp) $display("FAIL random_cyc%0d got %h exp %h", cyc, got, exp);
      else passed++;
    end
    rst = 0;
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_ov();
    test_ades_bd();
    test_int();
    test_eret_busy();
    test_stall_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
